// File: rtl/test_seq_pkg.sv
// Shared definitions for the 6502 test sequencer: FSM states and the default
// mailbox map, also used by the assembler ROM headers.
package test_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] MAILBOX_ADDR_DEF    = 16'hFFF0;
    localparam logic [15:0] CHECKPOINT_ADDR_DEF = 16'hFFF1;
    localparam logic [7:0]  PASS_CODE_DEF       = 8'h01;

endpackage

// File: rtl/test_sequencer_if.sv
// Core memory-bus write snoop: the core drives it, the sequencer observes it
// in parallel with the memory.
interface test_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_enable;

    modport master (output address, output wr_data, output wr_enable);
    modport slave  (input  address, input  wr_data, input  wr_enable);
endinterface

// File: rtl/watchdog_counter.sv
// Saturating up-counter with synchronous clear, count enable and a
// terminal-count flag raised while the count equals TERMINAL.
module watchdog_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/test_sequencer.sv
// Test controller around the 6502 core: sequences core reset, snoops the bus
// for mailbox/checkpoint writes and flags runaway programs via a watchdog.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    RESET_CYCLES   = 4,
    parameter int                    TIMEOUT_CYCLES = 2000,
    parameter int                    CNT_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] MAILBOX_ADDR   = ADDR_WIDTH'(MAILBOX_ADDR_DEF),
    parameter logic [DATA_WIDTH-1:0] PASS_CODE      = DATA_WIDTH'(PASS_CODE_DEF)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    test_sequencer_if.slave       bus,
    output logic                  proc_resetn,
    output logic                  running,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [DATA_WIDTH-1:0] fail_code,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [7:0]            checkpoint_count,
    output logic [DATA_WIDTH-1:0] last_checkpoint
);

    localparam logic [ADDR_WIDTH-1:0] CKPT_ADDR = MAILBOX_ADDR + ADDR_WIDTH'(1);
    localparam int                    HOLD_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam bit                    WD_ON     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0]  WD_LAST   = WD_ON ? CNT_WIDTH'(TIMEOUT_CYCLES - 1)
                                                        : '1;

    state_t state_q, state_d;

    logic                  in_run;
    logic                  start_run;
    logic                  mb_wr;
    logic                  ck_wr;
    logic                  wd_expire;
    logic                  hold_tc;
    logic                  cyc_tc;
    logic                  cyc_en;
    logic [HOLD_W-1:0]     hold_count_unused;

    logic                  pass_q;
    logic                  fail_q;
    logic                  timeout_q;
    logic [DATA_WIDTH-1:0] fail_code_q;
    logic [7:0]            ckpt_cnt_q;
    logic [DATA_WIDTH-1:0] last_ckpt_q;

    assign in_run    = (state_q == ST_RUN);
    assign start_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign mb_wr     = in_run && bus.wr_enable && (bus.address == MAILBOX_ADDR);
    assign ck_wr     = in_run && bus.wr_enable && (bus.address == CKPT_ADDR);
    // A mailbox write in the expiry cycle pre-empts the timeout.
    assign wd_expire = WD_ON && in_run && cyc_tc && !mb_wr;
    // cycle_count freezes on the edge that leaves RUN, so it reports the last RUN cycle.
    assign cyc_en    = in_run && (state_d == ST_RUN);

    watchdog_counter #(
        .WIDTH    (HOLD_W),
        .TERMINAL (HOLD_LAST)
    ) u_hold_cnt (
        .clk   (clk),
        .rst_n (resetn),
        .clr   (start_run),
        .en    (state_q == ST_HOLD),
        .count (hold_count_unused),
        .tc    (hold_tc)
    );

    watchdog_counter #(
        .WIDTH    (CNT_WIDTH),
        .TERMINAL (WD_LAST)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (resetn),
        .clr   (start_run),
        .en    (cyc_en),
        .count (cycle_count),
        .tc    (cyc_tc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start)              state_d = ST_HOLD;
            ST_HOLD:          if (hold_tc)            state_d = ST_RUN;
            ST_RUN:           if (mb_wr || wd_expire) state_d = ST_DONE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= '0;
            ckpt_cnt_q  <= '0;
            last_ckpt_q <= '0;
        end else if (start_run) begin
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= '0;
            ckpt_cnt_q  <= '0;
            last_ckpt_q <= '0;
        end else begin
            if (mb_wr) begin
                if (bus.wr_data == PASS_CODE) begin
                    pass_q <= 1'b1;
                end else begin
                    fail_q      <= 1'b1;
                    fail_code_q <= bus.wr_data;
                end
            end else if (wd_expire) begin
                timeout_q <= 1'b1;
            end
            if (ck_wr) begin
                if (ckpt_cnt_q != 8'hFF) begin
                    ckpt_cnt_q <= ckpt_cnt_q + 8'd1;
                end
                last_ckpt_q <= bus.wr_data;
            end
        end
    end

    assign proc_resetn      = in_run;
    assign running          = in_run;
    assign done             = (state_q == ST_DONE);
    assign pass             = pass_q;
    assign fail             = fail_q;
    assign timeout          = timeout_q;
    assign fail_code        = fail_code_q;
    assign checkpoint_count = ckpt_cnt_q;
    assign last_checkpoint  = last_ckpt_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: reset sequencing, pass/fail/timeout,
// checkpoints, ignored events, restart, async reset and saturation.
module tb_test_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        start_b;

    logic        proc_resetn, running, done, pass, fail, timeout;
    logic [7:0]  fail_code, checkpoint_count, last_checkpoint;
    logic [31:0] cycle_count;

    logic        proc_resetn_b, running_b, done_b, pass_b, fail_b, timeout_b;
    logic [7:0]  fail_code_b, checkpoint_count_b, last_checkpoint_b;
    logic [31:0] cycle_count_b;

    int compared   = 0;
    int mismatched = 0;

    test_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_if ();

    test_sequencer #(
        .RESET_CYCLES   (4),
        .TIMEOUT_CYCLES (100)
    ) u_dut (
        .clk              (clk),
        .resetn           (resetn),
        .start            (start),
        .bus              (bus_if.slave),
        .proc_resetn      (proc_resetn),
        .running          (running),
        .done             (done),
        .pass             (pass),
        .fail             (fail),
        .timeout          (timeout),
        .fail_code        (fail_code),
        .cycle_count      (cycle_count),
        .checkpoint_count (checkpoint_count),
        .last_checkpoint  (last_checkpoint)
    );

    // Watchdog disabled: used for the long checkpoint-saturation run.
    test_sequencer #(
        .RESET_CYCLES   (4),
        .TIMEOUT_CYCLES (0)
    ) u_dut_nowd (
        .clk              (clk),
        .resetn           (resetn),
        .start            (start_b),
        .bus              (bus_if.slave),
        .proc_resetn      (proc_resetn_b),
        .running          (running_b),
        .done             (done_b),
        .pass             (pass_b),
        .fail             (fail_b),
        .timeout          (timeout_b),
        .fail_code        (fail_code_b),
        .cycle_count      (cycle_count_b),
        .checkpoint_count (checkpoint_count_b),
        .last_checkpoint  (last_checkpoint_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        bus_if.address   = addr;
        bus_if.wr_data   = data;
        bus_if.wr_enable = 1'b1;
        step();
        bus_if.wr_enable = 1'b0;
    endtask

    // Pulse start from IDLE/DONE and advance to the first RUN cycle.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        resetn           = 1'b0;
        start            = 1'b0;
        start_b          = 1'b0;
        bus_if.address   = 16'h0000;
        bus_if.wr_data   = 8'h00;
        bus_if.wr_enable = 1'b0;
        repeat (2) step();

        check("rst_proc_resetn", 32'(proc_resetn), 32'd0);
        check("rst_running",     32'(running),     32'd0);
        check("rst_done",        32'(done),        32'd0);
        check("rst_flags",       {29'd0, pass, fail, timeout}, 32'd0);
        check("rst_fail_code",   32'(fail_code),   32'd0);
        check("rst_cycle_count", cycle_count,      32'd0);
        check("rst_ckpt_count",  32'(checkpoint_count), 32'd0);
        check("rst_last_ckpt",   32'(last_checkpoint),  32'd0);

        resetn = 1'b1;
        step();

        // Reset sequencing: proc_resetn low for exactly four cycles.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("hold_proc_resetn", 32'(proc_resetn), 32'd0);
            check("hold_running",     32'(running),     32'd0);
            step();
        end
        check("run_proc_resetn", 32'(proc_resetn), 32'd1);
        check("run_running",     32'(running),     32'd1);
        check("run_cycle0",      cycle_count,      32'd0);

        // Pass at RUN cycle 37.
        repeat (37) step();
        check("run_cycle37", cycle_count, 32'd37);
        bus_write(16'hFFF0, 8'h01);
        check("pass_pass",        32'(pass),        32'd1);
        check("pass_done",        32'(done),        32'd1);
        check("pass_running",     32'(running),     32'd0);
        check("pass_proc_resetn", 32'(proc_resetn), 32'd0);
        check("pass_cycle_held",  cycle_count,      32'd37);
        check("pass_fail_to",     {30'd0, fail, timeout}, 32'd0);

        // Writes in DONE are ignored.
        bus_write(16'hFFF0, 8'h5C);
        bus_write(16'hFFF1, 8'h33);
        check("done_wr_pass",      32'(pass),             32'd1);
        check("done_wr_fail",      32'(fail),             32'd0);
        check("done_wr_fail_code", 32'(fail_code),        32'd0);
        check("done_wr_ckpt",      32'(checkpoint_count), 32'd0);
        check("done_wr_cycle",     cycle_count,           32'd37);

        // Restart from DONE clears results; mailbox writes during HOLD ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_done",  32'(done),        32'd0);
        check("restart_pass",  32'(pass),        32'd0);
        check("restart_cycle", cycle_count,      32'd0);
        check("restart_prn",   32'(proc_resetn), 32'd0);
        bus_if.address   = 16'hFFF0;
        bus_if.wr_data   = 8'h5C;
        bus_if.wr_enable = 1'b1;
        repeat (4) step();
        bus_if.wr_enable = 1'b0;
        check("hold_wr_running", 32'(running), 32'd1);
        check("hold_wr_fail",    32'(fail),    32'd0);
        check("hold_wr_done",    32'(done),    32'd0);

        // Checkpoints, start ignored in RUN, then fail.
        bus_write(16'hFFF1, 8'hA0);
        bus_write(16'hFFF1, 8'hA1);
        check("ckpt_count", 32'(checkpoint_count), 32'd2);
        check("ckpt_last",  32'(last_checkpoint),  32'hA1);
        check("ckpt_cycle", cycle_count,           32'd2);
        check("ckpt_running", 32'(running),        32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("run_start_running", 32'(running), 32'd1);
        check("run_start_cycle",   cycle_count,  32'd3);
        bus_write(16'hFFF0, 8'h5C);
        check("fail_fail",      32'(fail),             32'd1);
        check("fail_code",      32'(fail_code),        32'h5C);
        check("fail_pass",      32'(pass),             32'd0);
        check("fail_done",      32'(done),             32'd1);
        check("fail_ckpt_kept", 32'(checkpoint_count), 32'd2);

        // Timeout exactly 100 cycles after running rises.
        do_start();
        check("to_running",     32'(running),          32'd1);
        check("to_fail_clear",  {30'd0, fail, pass},   32'd0);
        check("to_code_clear",  32'(fail_code),        32'd0);
        check("to_ckpt_clear",  32'(checkpoint_count), 32'd0);
        check("to_last_clear",  32'(last_checkpoint),  32'd0);
        repeat (99) step();
        check("to_pre_timeout", 32'(timeout), 32'd0);
        check("to_pre_running", 32'(running), 32'd1);
        check("to_pre_cycle",   cycle_count,  32'd99);
        step();
        check("to_timeout", 32'(timeout), 32'd1);
        check("to_done",    32'(done),    32'd1);
        check("to_running_low", 32'(running), 32'd0);
        check("to_cycle",   cycle_count,  32'd99);
        check("to_pass",    32'(pass),    32'd0);

        // Mailbox pass in the expiry cycle wins over timeout.
        do_start();
        repeat (99) step();
        bus_write(16'hFFF0, 8'h01);
        check("race_pass",    32'(pass),    32'd1);
        check("race_timeout", 32'(timeout), 32'd0);
        check("race_done",    32'(done),    32'd1);

        // Checkpoint in the expiry cycle is recorded and timeout still taken.
        do_start();
        repeat (99) step();
        bus_write(16'hFFF1, 8'h77);
        check("ckto_timeout", 32'(timeout),          32'd1);
        check("ckto_count",   32'(checkpoint_count), 32'd1);
        check("ckto_last",    32'(last_checkpoint),  32'h77);

        // Asynchronous reset mid-RUN, between clock edges.
        do_start();
        bus_write(16'hFFF1, 8'h12);
        repeat (9) step();
        check("ar_pre_running", 32'(running), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("ar_proc_resetn", 32'(proc_resetn),      32'd0);
        check("ar_running",     32'(running),          32'd0);
        check("ar_cycle",       cycle_count,           32'd0);
        check("ar_ckpt",        32'(checkpoint_count), 32'd0);
        check("ar_last",        32'(last_checkpoint),  32'd0);
        #1 resetn = 1'b1;
        step();
        check("ar_idle_running", 32'(running), 32'd0);
        check("ar_idle_done",    32'(done),    32'd0);

        // 300 checkpoint writes saturate at 255 (watchdog disabled instance).
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        repeat (4) step();
        check("sat_running", 32'(running_b), 32'd1);
        for (int i = 0; i < 300; i++) begin
            bus_if.address   = 16'hFFF1;
            bus_if.wr_data   = 8'(i);
            bus_if.wr_enable = 1'b1;
            step();
        end
        bus_if.wr_enable = 1'b0;
        check("sat_count",       32'(checkpoint_count_b), 32'd255);
        check("sat_last",        32'(last_checkpoint_b),  32'h2B);
        check("sat_no_timeout",  32'(timeout_b),          32'd0);
        check("sat_still_run",   32'(running_b),          32'd1);
        check("sat_cycle",       cycle_count_b,           32'd300);
        check("sat_idle_ignore", 32'(checkpoint_count),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
